sync_fifo: RTL
==============

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8: width of din/dout.
REQ-002 SHALL provide parameter DEPTH, default 256: word capacity, power of two, minimum 4.
REQ-003 SHALL provide port sys_clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL provide port sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL provide port wr_en, input, 1: write request.
REQ-006 SHALL provide port din, input, DATA_WIDTH: write data.
REQ-007 SHALL provide port rd_en, input, 1: read request.
REQ-008 SHALL provide port dout, output, DATA_WIDTH: registered read data.
REQ-009 SHALL provide port valid, output, 1: dout holds a newly read word.
REQ-010 SHALL provide port full, output, 1: count == DEPTH.
REQ-011 SHALL provide port almost_full, output, 1: count >= DEPTH-1.
REQ-012 SHALL provide port empty, output, 1: count == 0.
REQ-013 SHALL provide port almost_empty, output, 1: count <= 1.
REQ-014 SHALL provide port data_count, output, log2(DEPTH)+1: words stored.
REQ-015 SHALL provide port overflow, output, 1: one-cycle pulse on a rejected write.
REQ-016 SHALL provide port underflow, output, 1: one-cycle pulse on a rejected read.
REQ-017 SHALL provide port rst_busy, output, 1: FIFO not yet accepting traffic after reset.

Function
REQ-018 SHALL accept a write when wr_en=1, full=0, rst_busy=0: store din at wr_ptr, advance wr_ptr.
REQ-019 SHALL accept a read when rd_en=1, empty=0, rst_busy=0: dout <= mem[rd_ptr] at the next edge, valid=1 for that cycle, advance rd_ptr.
REQ-020 SHALL hold dout unchanged and drive valid=0 in cycles with no accepted read.
REQ-021 SHALL wrap both pointers modulo DEPTH with no skipped or repeated address.
REQ-022 SHALL compute full/empty/almost flags and data_count from registered state only, updated the cycle after the accepted access.
REQ-023 SHALL reject wr_en at full even when rd_en=1 the same cycle; the read proceeds, overflow pulses.
REQ-024 SHALL reject rd_en at empty even when wr_en=1 the same cycle; the write proceeds, underflow pulses, no bypass to dout.
REQ-025 SHALL keep data_count unchanged when both a write and a read are accepted in one cycle.
REQ-026 SHALL ignore wr_en/rd_en while rst_busy=1 without raising overflow/underflow.

Reset
REQ-027 SHALL, on sys_rst_n=0, immediately clear pointers and data_count, set empty=1, almost_empty=1, full=0, almost_full=0, valid=0, overflow=0, underflow=0, dout=0.
REQ-028 SHALL discard stored contents on reset asserted mid-operation; memory array itself not cleared.
REQ-029 SHALL drive rst_busy=1 while sys_rst_n=0.

Configuration
REQ-030 SHALL honour macro SYNC_FIFO_RST_BUSY_EN.
REQ-031 With SYNC_FIFO_RST_BUSY_EN defined, SHALL hold rst_busy=1 for 8 sys_clk cycles after sys_rst_n deasserts (3-bit counter), then 0.
REQ-032 Without SYNC_FIFO_RST_BUSY_EN, SHALL tie rst_busy to 0 outside reset; traffic accepted the first edge after deassertion.

Structure
REQ-033 SHALL place default DATA_WIDTH, DEPTH, the rst_busy hold count (8) and a pointer-width function in package sync_fifo_pkg.
REQ-034 SHALL instantiate sub-module sync_fifo_ram (simple dual-port array, one write port, one registered read port); pointer/flag logic stays in sync_fifo.

Verification
REQ-035 Reset release with macro defined, wr_en=1 held -> rst_busy high 8 cycles, no writes stored, first write on cycle 9, overflow never pulses.
REQ-036 Write 0x00..0xFF (DEPTH=256), then read 256 -> dout 0x00..0xFF in order, valid each cycle, almost_full at count 255, full at 256, empty after final read.
REQ-037 At full, wr_en=1 + rd_en=1 with din=0xAA -> overflow pulses, count goes 256->255, 0xAA absent from readout.
REQ-038 At empty, wr_en=1 din=0x5C + rd_en=1 -> underflow pulses, valid=0, count 0->1, next read returns 0x5C.
REQ-039 Count=100, simultaneous write/read for 300 cycles -> data_count stays 100, pointers wrap, readout order preserved.
REQ-040 sys_rst_n pulled low at count=50 mid-burst -> all flags/outputs at reset values within the same cycle, subsequent first read returns post-reset data only.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared defaults and helpers for the sync_fifo block.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 256;

  // Number of clock cycles rst_busy stays high after reset release
  // (only used when SYNC_FIFO_RST_BUSY_EN is defined).
  localparam int RST_BUSY_CYCLES    = 8;

  // Address width needed to index a power-of-two deep array.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ram
// Description : Simple dual-port storage array for sync_fifo: one write port
//               and one registered read port. The array itself has no reset;
//               only the read register is cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = ptr_width(DEFAULT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int WORDS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // Write port: store the incoming word at the write address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port: holds its value unless a read is performed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered read data, status flags,
//               occupancy count and overflow/underflow pulses. Pointer and
//               flag logic live here; storage is in sync_fifo_ram.
//               Optional macro SYNC_FIFO_RST_BUSY_EN adds a post-reset
//               hold-off window (rst_busy) during which traffic is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     valid,
  output logic                     full,
  output logic                     almost_full,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [ptr_width(DEPTH):0] data_count,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     rst_busy
);

  localparam int           AW        = ptr_width(DEPTH);
  localparam logic [AW:0]  CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]  CNT_AFULL = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]  CNT_ONE   = (AW+1)'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          busy;
  logic          wr_accept;
  logic          rd_accept;

`ifdef SYNC_FIFO_RST_BUSY_EN
  localparam logic [2:0] BUSY_LAST = 3'(RST_BUSY_CYCLES - 1);

  logic [2:0] busy_cnt;
  logic       busy_hold;

  // Keep the FIFO closed for a fixed number of cycles after reset release.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      busy_cnt  <= '0;
      busy_hold <= 1'b1;
    end else if (busy_hold) begin
      busy_cnt <= busy_cnt + 3'd1;
      if (busy_cnt == BUSY_LAST) begin
        busy_hold <= 1'b0;
      end
    end
  end

  assign busy = busy_hold;
`else
  assign busy = 1'b0;
`endif

  // rst_busy is also forced high combinationally while reset is asserted.
  assign rst_busy = ~sys_rst_n | busy;

  // Full-side write is rejected even if a read frees a slot the same cycle;
  // empty-side read is rejected even if a write fills it (no bypass).
  assign wr_accept = wr_en & ~full  & ~busy;
  assign rd_accept = rd_en & ~empty & ~busy;

  // Flags decode the registered occupancy only.
  assign full         = (count == CNT_FULL);
  assign almost_full  = (count >= CNT_AFULL);
  assign empty        = (count == '0);
  assign almost_empty = (count <= CNT_ONE);
  assign data_count   = count;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // One-cycle status pulses; requests during the busy window are not errors.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      valid     <= rd_accept;
      overflow  <= wr_en & full  & ~busy;
      underflow <= rd_en & empty & ~busy;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr),
    .rd_data (dout)
  );

endmodule
`default_nettype wire
